// File: rtl/tt_um_vending_machine.sv
// tt_um_vending_machine: coin-operated vending controller with edge-detected inputs
// and a multiplexed credit/change amount bus.
module tt_um_vending_machine (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    logic [6:0] prev, ev;
    logic [7:0] credit, credit_d, amount_d, price, coin, sum;
    logic [1:0] last_id, id_d;
    logic       disp_d, chg_d, insuf_d, rej_d;
    logic       unused;

    assign unused = &{ena, uio_in, ui_in[7], 1'b0};
    assign uio_oe = 8'hFF;
    assign ev     = ui_in[6:0] & ~prev;
    assign price  = 8'd15 + 8'(ui_in[4:3]) * 8'd5;
    assign coin   = ev[2] ? 8'd25 : ev[1] ? 8'd10 : ev[0] ? 8'd5 : 8'd0;
    assign sum    = credit + coin;

    // Priority: cancel > buy > coins; lower-priority edges in the same cycle are dropped.
    always_comb begin
        credit_d = credit;
        amount_d = credit;
        id_d     = last_id;
        disp_d   = 1'b0;
        chg_d    = 1'b0;
        insuf_d  = 1'b0;
        rej_d    = 1'b0;
        if (ev[6]) begin
            chg_d    = 1'b1;
            credit_d = 8'd0;
        end else if (ev[5]) begin
            if (credit >= price) begin
                disp_d   = 1'b1;
                chg_d    = 1'b1;
                id_d     = ui_in[4:3];
                amount_d = credit - price;
                credit_d = 8'd0;
            end else begin
                insuf_d = 1'b1;
            end
        end else if (|ev[2:0]) begin
            if (sum <= 8'd99) begin
                credit_d = sum;
                amount_d = sum;
            end else begin
                rej_d = 1'b1;
            end
        end
    end

    // prev resets high so inputs held through reset must fall and rise again to act.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev    <= 7'h7F;
            credit  <= 8'd0;
            last_id <= 2'd0;
            uo_out  <= 8'd0;
            uio_out <= 8'd0;
        end else begin
            prev    <= ui_in[6:0];
            credit  <= credit_d;
            last_id <= id_d;
            uo_out  <= {1'b0, credit_d != 8'd0, id_d, rej_d, insuf_d, chg_d, disp_d};
            uio_out <= amount_d;
        end
    end
endmodule

// File: tb/tb_tt_um_vending_machine.sv
// tb_tt_um_vending_machine: table-driven checks with a scoreboard queue of expected outputs.
module tb_tt_um_vending_machine;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'd0;
    logic [7:0] uio_in = 8'd0;
    logic [7:0] uo_out, uio_out, uio_oe;

    typedef struct {
        logic [7:0] ui;
        logic [7:0] uo;
        logic [7:0] uio;
    } vec_t;

    vec_t tbl [0:39];
    vec_t sb [$];
    int   passed = 0;
    int   total  = 0;

    tt_um_vending_machine dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d] got %h want %h", name, idx, act, exp);
    endtask

    task automatic step(input int idx, input logic [7:0] ui, input logic [7:0] uo, input logic [7:0] uio);
        vec_t e;
        ui_in = ui;
        sb.push_back('{ui, uo, uio});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("uo_out", idx, uo_out, e.uo);
        check("uio_out", idx, uio_out, e.uio);
    endtask

    initial begin
        tbl = '{
            '{8'h02, 8'h40, 8'd10}, '{8'h00, 8'h40, 8'd10}, '{8'h02, 8'h40, 8'd20}, '{8'h08, 8'h40, 8'd20},
            '{8'h28, 8'h13, 8'd0 }, '{8'h08, 8'h10, 8'd0 }, '{8'h00, 8'h10, 8'd0 }, '{8'h04, 8'h50, 8'd25},
            '{8'h06, 8'h50, 8'd35}, '{8'h20, 8'h03, 8'd20}, '{8'h00, 8'h00, 8'd0 }, '{8'h01, 8'h40, 8'd5 },
            '{8'h38, 8'h44, 8'd5 }, '{8'h40, 8'h02, 8'd5 }, '{8'h00, 8'h00, 8'd0 }, '{8'h04, 8'h40, 8'd25},
            '{8'h00, 8'h40, 8'd25}, '{8'h04, 8'h40, 8'd50}, '{8'h00, 8'h40, 8'd50}, '{8'h04, 8'h40, 8'd75},
            '{8'h00, 8'h40, 8'd75}, '{8'h04, 8'h48, 8'd75}, '{8'h00, 8'h40, 8'd75}, '{8'h02, 8'h40, 8'd85},
            '{8'h01, 8'h40, 8'd90}, '{8'h02, 8'h48, 8'd90}, '{8'h01, 8'h40, 8'd95}, '{8'h40, 8'h02, 8'd95},
            '{8'h00, 8'h00, 8'd0 }, '{8'h40, 8'h02, 8'd0 }, '{8'h00, 8'h00, 8'd0 }, '{8'h02, 8'h40, 8'd10},
            '{8'h44, 8'h02, 8'd10}, '{8'h00, 8'h00, 8'd0 }, '{8'h04, 8'h40, 8'd25}, '{8'h21, 8'h03, 8'd10},
            '{8'h00, 8'h00, 8'd0 }, '{8'h04, 8'h40, 8'd25}, '{8'h30, 8'h23, 8'd0 }, '{8'h00, 8'h20, 8'd0 }
        };
        repeat (3) @(posedge clk);
        #1;
        check("rst_uo", 0, uo_out, 8'h00);
        check("rst_uio", 0, uio_out, 8'h00);
        check("rst_oe", 0, uio_oe, 8'hFF);
        rst_n = 1'b1;
        step(100, 8'h00, 8'h00, 8'd0);
        check("idle_oe", 0, uio_oe, 8'hFF);
        for (int i = 0; i < 40; i++) step(i, tbl[i].ui, tbl[i].uo, tbl[i].uio);
        step(200, 8'h04, 8'h60, 8'd25);
        ui_in = 8'h40;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_uo", 0, uo_out, 8'h00);
        check("midrst_uio", 0, uio_out, 8'h00);
        ui_in = 8'h01;
        @(posedge clk);
        #1;
        check("inrst_uo", 0, uo_out, 8'h00);
        check("inrst_oe", 0, uio_oe, 8'hFF);
        rst_n = 1'b1;
        step(201, 8'h01, 8'h00, 8'd0);
        step(202, 8'h01, 8'h00, 8'd0);
        step(203, 8'h00, 8'h00, 8'd0);
        step(204, 8'h01, 8'h40, 8'd5);
        step(205, 8'h40, 8'h02, 8'd5);
        step(206, 8'h00, 8'h00, 8'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tt_um_vending_machine.md
TT_UM_VENDING_MACHINE -- requirements
Module: tt_um_vending_machine

Interface
REQ-001 SHALL expose clk, input, 1, system clock, all state updates on rising edge.
REQ-002 SHALL expose rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL expose ena, input, 1, design enable; ignored, design always runs.
REQ-004 SHALL expose ui_in, input, 8, with these bits:
- [0] coin 5c
- [1] coin 10c
- [2] coin 25c
- [4:3] product select
- [5] buy
- [6] cancel
- [7] unused
REQ-005 SHALL expose uio_in, input, 8, unused.
REQ-006 SHALL expose uo_out, output, 8, with these bits:
- [0] dispense
- [1] change_valid
- [2] insufficient
- [3] coin_reject
- [5:4] dispensed product id
- [6] credit_nonzero
- [7] 0
REQ-007 SHALL expose uio_out, output, 8, amount bus: credit normally, change amount in change_valid cycle.
REQ-008 SHALL expose uio_oe, output, 8, constant 8'hFF.

Function
REQ-009 SHALL treat all ui_in bits as synchronous to clk, with no synchronizer.
REQ-010 SHALL register ui_in[6:0] every cycle as prev.
REQ-011 SHALL define event = ui_in & ~prev, so only 0->1 transitions act and held levels are ignored.
REQ-012 SHALL process at most one event per cycle, priority cancel > buy > coin25 > coin10 > coin5; lower-priority events in the same cycle SHALL be discarded.
REQ-013 SHALL hold credit as an 8-bit unsigned cents register, range 0..99.
REQ-014 SHALL add a coin to credit when credit+coin <= 99.
REQ-015 SHALL, when credit+coin > 99, leave credit unchanged and pulse coin_reject for one cycle.
REQ-016 SHALL use prices by ui_in[4:3], sampled in the buy-event cycle: 00=15, 01=20, 10=25, 11=30.
REQ-017 SHALL, on buy with credit >= price, in the next cycle:
- pulse dispense and change_valid for one cycle
- drive uo_out[5:4] with the product id
- drive uio_out with credit-price
- clear credit to 0
REQ-018 SHALL, on buy with credit < price, pulse insufficient for one cycle and leave credit unchanged.
REQ-019 SHALL, on cancel, in the next cycle:
- pulse change_valid for one cycle
- drive uio_out with the full credit
- clear credit to 0
REQ-020 SHALL, on cancel with credit 0, still pulse change_valid with uio_out=0.
REQ-021 SHALL make all pulse outputs exactly one cycle wide, registered, and asserted the cycle after the event edge.
REQ-022 SHALL hold uo_out[5:4] at the last dispensed id until the next dispense or reset.
REQ-023 SHALL drive uio_out = credit in every cycle where change_valid=0.
REQ-024 SHALL make credit_nonzero a registered flag, credit != 0.
REQ-025 SHALL keep all outputs registered, with no combinational ui_in->output path.
REQ-026 SHALL produce at least one cycle of dispense or change_valid per transaction; back-to-back events on consecutive cycles SHALL each be honoured.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force credit, uo_out and uio_out to 0 and the last product id to 0.
REQ-028 SHALL, while rst_n=0, set prev to 7'h7F so inputs held high through reset generate no event until released and re-asserted.
REQ-029 SHALL keep uio_oe at 8'hFF during and after reset.
REQ-030 SHALL, on reset asserted mid-transaction, abandon all pending pulses and lose credit with no change output.

Verification
REQ-031 Reset, then idle -> uo_out=0, uio_out=0, uio_oe=FF.
REQ-032 Pulse coin10, coin10, then buy with sel=01 -> uio_out 10 then 20; next cycle dispense=1, change_valid=1, uio_out=0, uo_out[5:4]=01; then credit 0.
REQ-033 Coin25, coin10, buy with sel=00 -> dispense, change_valid, uio_out=20 for one cycle, then uio_out=0.
REQ-034 Coin5, buy with sel=11 -> insufficient pulse, uio_out stays 5; cancel -> change_valid with uio_out=5, then 0.
REQ-035 Four coin25 -> credit 75 after three; fourth rejected with coin_reject pulse, credit stays 75; coin10 accepted -> 85.
REQ-036 Coin25 and cancel rising the same cycle with credit 10 -> cancel wins, change_valid with uio_out=10, coin ignored; ui_in[0] held high across reset release -> no credit.
